mem_arbiter: RTL and testbench

//   Two-port arbiter/sequencer for the single-port Memory block (active-low Mem_En/Write_EN).

---
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the single-port Memory block.
// Each grant runs IDLE -> ACCESS -> RESP; Memory enables are active-low.
module mem_arbiter #(
  parameter int unsigned DATA_WIDTH    = 16,
  parameter int unsigned ADDRESS_WIDTH = 8
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     Req0,
  input  logic                     Req1,
  input  logic                     Wr0,
  input  logic                     Wr1,
  input  logic [ADDRESS_WIDTH-1:0] Addr0,
  input  logic [ADDRESS_WIDTH-1:0] Addr1,
  input  logic [DATA_WIDTH-1:0]    WData0,
  input  logic [DATA_WIDTH-1:0]    WData1,
  output logic                     Ack0,
  output logic                     Ack1,
  output logic [DATA_WIDTH-1:0]    RData0,
  output logic [DATA_WIDTH-1:0]    RData1,
  output logic [ADDRESS_WIDTH-1:0] Mem_Address,
  output logic [DATA_WIDTH-1:0]    Mem_DIn,
  output logic                     Mem_Write_EN,
  output logic                     Mem_En,
  input  logic [DATA_WIDTH-1:0]    Mem_DOut,
  output logic                     Busy
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned AW = ADDRESS_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic            gnt_q, gnt_d;
  logic            ack0_q, ack0_d;
  logic            ack1_q, ack1_d;
  logic [DW-1:0]   rdata0_q, rdata0_d;
  logic [DW-1:0]   rdata1_q, rdata1_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   din_q, din_d;
  logic            we_n_q, we_n_d;
  logic            en_n_q, en_n_d;
  logic            busy_q, busy_d;
  logic            sel_c;
  logic            wr_sel_c;

  // Next-state and registered-output logic; memory is enabled only in ACCESS.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    addr_d       = addr_q;
    din_d        = din_q;
    we_n_d       = 1'b1;
    en_n_d       = 1'b1;
    busy_d       = 1'b0;
    sel_c        = 1'b0;
    wr_sel_c     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (Req0 || Req1) begin
          // On a tie the port that did not win last time is served.
          sel_c        = (Req0 && Req1) ? ~last_grant_q : Req1;
          wr_sel_c     = sel_c ? Wr1 : Wr0;
          gnt_d        = sel_c;
          last_grant_d = sel_c;
          addr_d       = sel_c ? Addr1 : Addr0;
          din_d        = sel_c ? WData1 : WData0;
          we_n_d       = ~wr_sel_c;
          en_n_d       = 1'b0;
          busy_d       = 1'b1;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        if (gnt_q) ack1_d = 1'b1;
        else       ack0_d = 1'b1;
        // we_n_q still reflects the direction of the access in flight.
        if (we_n_q) begin
          if (gnt_q) rdata1_d = Mem_DOut;
          else       rdata0_d = Mem_DOut;
        end
        busy_d  = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      addr_q       <= '0;
      din_q        <= '0;
      we_n_q       <= 1'b1;
      en_n_q       <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      addr_q       <= addr_d;
      din_q        <= din_d;
      we_n_q       <= we_n_d;
      en_n_q       <= en_n_d;
      busy_q       <= busy_d;
    end
  end

  assign Ack0         = ack0_q;
  assign Ack1         = ack1_q;
  assign RData0       = rdata0_q;
  assign RData1       = rdata1_q;
  assign Mem_Address  = addr_q;
  assign Mem_DIn      = din_q;
  assign Mem_Write_EN = we_n_q;
  assign Mem_En       = en_n_q;
  assign Busy         = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed transaction table, multi-cycle corner sequences,
// and randomized requesters compared cycle by cycle against a transaction-level model.
module tb_mem_arbiter;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Req0 = 1'b0, Req1 = 1'b0;
  logic        Wr0 = 1'b0, Wr1 = 1'b0;
  logic [7:0]  Addr0 = '0, Addr1 = '0;
  logic [15:0] WData0 = '0, WData1 = '0;
  logic        Ack0, Ack1;
  logic [15:0] RData0, RData1;
  logic [7:0]  Mem_Address;
  logic [15:0] Mem_DIn;
  logic        Mem_Write_EN, Mem_En, Busy;
  logic [15:0] Mem_DOut;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.DATA_WIDTH(16), .ADDRESS_WIDTH(8)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .Req1(Req1), .Wr0(Wr0), .Wr1(Wr1),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Ack0(Ack0), .Ack1(Ack1), .RData0(RData0), .RData1(RData1),
    .Mem_Address(Mem_Address), .Mem_DIn(Mem_DIn),
    .Mem_Write_EN(Mem_Write_EN), .Mem_En(Mem_En),
    .Mem_DOut(Mem_DOut), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // Single-port memory: samples at negedge when Mem_En is low.
  logic [15:0] mem [256];
  bit mem_loaded = 1'b0;
  always @(negedge Clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      mem[0] = 16'h9202;
      mem[1] = 16'h9304;
      mem[2] = 16'h2621;
      mem_loaded = 1'b1;
    end
    if (Mem_En === 1'b0) begin
      Mem_DOut <= mem[Mem_Address];
      if (Mem_Write_EN === 1'b0) mem[Mem_Address] = Mem_DIn;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_port(input bit p, input bit rq, input bit wr, input logic [7:0] a,
                            input logic [15:0] d);
    if (p) begin Req1 = rq; Wr1 = wr; Addr1 = a; WData1 = d; end
    else   begin Req0 = rq; Wr0 = wr; Addr0 = a; WData0 = d; end
  endtask

  typedef struct {
    bit          port;
    bit          wr;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_r0;
    logic [15:0] exp_r1;
  } vec_t;

  // One isolated transaction from IDLE; Ack must appear on the second sample only.
  task automatic run_vec(input vec_t v, input string tag);
    logic [3:0] tr0, tr1, en_tr;
    tr0 = '0; tr1 = '0; en_tr = '0;
    drive_port(v.port, 1'b1, v.wr, v.addr, v.wdata);
    for (int c = 0; c < 4; c++) begin
      tick();
      tr0[c] = Ack0;
      tr1[c] = Ack1;
      en_tr[c] = ~Mem_En;
      if (c == 1) drive_port(v.port, 1'b0, 1'b0, 8'h00, 16'h0000);
    end
    chk({tag, "_ack0"}, 64'(tr0), v.port ? 64'h0 : 64'h2);
    chk({tag, "_ack1"}, 64'(tr1), v.port ? 64'h2 : 64'h0);
    chk({tag, "_memen"}, 64'(en_tr), 64'h1);
    chk({tag, "_rdata0"}, 64'(RData0), 64'(v.exp_r0));
    chk({tag, "_rdata1"}, 64'(RData1), 64'(v.exp_r1));
  endtask

  // Transaction-level reference model state.
  int          m_phase;
  bit          m_g, m_last, m_wr;
  logic [7:0]  m_addr;
  logic [15:0] m_din, m_rd, m_r0, m_r1;
  bit          m_ack0, m_ack1, m_en_n, m_we_n, m_busy;
  logic [15:0] ref_mem [256];

  task automatic model_reset();
    m_phase = 0; m_g = 1'b0; m_last = 1'b1; m_wr = 1'b0;
    m_addr = '0; m_din = '0; m_rd = '0; m_r0 = '0; m_r1 = '0;
    m_ack0 = 1'b0; m_ack1 = 1'b0; m_en_n = 1'b1; m_we_n = 1'b1; m_busy = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
  endtask

  // Phase counts cycles since the grant edge; a grant is possible only when it is 0.
  task automatic model_step();
    m_ack0 = 1'b0;
    m_ack1 = 1'b0;
    if (m_phase == 1) begin
      m_phase = 2;
      m_en_n = 1'b1;
      m_we_n = 1'b1;
      if (m_g) m_ack1 = 1'b1; else m_ack0 = 1'b1;
      if (!m_wr) begin
        if (m_g) m_r1 = m_rd; else m_r0 = m_rd;
      end
    end else if (m_phase == 2) begin
      m_phase = 0;
      m_busy = 1'b0;
    end else if (Req0 || Req1) begin
      m_g = (Req0 && Req1) ? !m_last : Req1;
      m_last = m_g;
      m_wr   = m_g ? Wr1 : Wr0;
      m_addr = m_g ? Addr1 : Addr0;
      m_din  = m_g ? WData1 : WData0;
      if (m_wr) ref_mem[m_addr] = m_din;
      else      m_rd = ref_mem[m_addr];
      m_en_n = 1'b0;
      m_we_n = !m_wr;
      m_busy = 1'b1;
      m_phase = 1;
    end
  endtask

  task automatic new_req(input bit p);
    drive_port(p, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 16'($urandom));
  endtask

  task automatic requester(input bit p, input bit rq, input bit acked);
    if (!rq) begin
      if ($urandom_range(0, 9) < 4) new_req(p);
    end else if (acked) begin
      if ($urandom_range(0, 1) == 1) new_req(p);
      else drive_port(p, 1'b0, 1'b0, 8'h00, 16'h0000);
    end else if (m_phase == 1 && m_g == p) begin
      // After grant the port may drop its request or scramble fields; both are ignored.
      if ($urandom_range(0, 9) == 0) drive_port(p, 1'b0, 1'b0, 8'h00, 16'h0000);
      else if ($urandom_range(0, 4) == 0) new_req(p);
    end
  endtask

  vec_t vecs[7];

  initial begin
    logic [11:0] t0, t1;
    logic [5:0]  s0, s1, se;
    logic [63:0] act, exp;

    vecs[0] = '{port: 1'b0, wr: 1'b0, addr: 8'h00, wdata: 16'h0000, exp_r0: 16'h9202, exp_r1: 16'h0000};
    vecs[1] = '{port: 1'b1, wr: 1'b1, addr: 8'h0A, wdata: 16'h0666, exp_r0: 16'h9202, exp_r1: 16'h0000};
    vecs[2] = '{port: 1'b0, wr: 1'b0, addr: 8'h0A, wdata: 16'h0000, exp_r0: 16'h0666, exp_r1: 16'h0000};
    vecs[3] = '{port: 1'b1, wr: 1'b0, addr: 8'h01, wdata: 16'h0000, exp_r0: 16'h0666, exp_r1: 16'h9304};
    vecs[4] = '{port: 1'b1, wr: 1'b0, addr: 8'h02, wdata: 16'h0000, exp_r0: 16'h0666, exp_r1: 16'h2621};
    vecs[5] = '{port: 1'b0, wr: 1'b1, addr: 8'h05, wdata: 16'h1234, exp_r0: 16'h0666, exp_r1: 16'h2621};
    vecs[6] = '{port: 1'b1, wr: 1'b0, addr: 8'h05, wdata: 16'h0000, exp_r0: 16'h0666, exp_r1: 16'h1234};

    // Asynchronous reset values, checked before any clock edge.
    #2 Reset = 1'b0;
    #1;
    chk("rst_ack0", 64'(Ack0), 64'h0);
    chk("rst_ack1", 64'(Ack1), 64'h0);
    chk("rst_rdata0", 64'(RData0), 64'h0);
    chk("rst_rdata1", 64'(RData1), 64'h0);
    chk("rst_addr", 64'(Mem_Address), 64'h0);
    chk("rst_din", 64'(Mem_DIn), 64'h0);
    chk("rst_we", 64'(Mem_Write_EN), 64'h1);
    chk("rst_en", 64'(Mem_En), 64'h1);
    chk("rst_busy", 64'(Busy), 64'h0);
    @(negedge Clk);
    #1 Reset = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Both ports hold read requests: grants alternate 0,1,0,1 three cycles apart.
    drive_port(1'b0, 1'b1, 1'b0, 8'h01, 16'h0000);
    drive_port(1'b1, 1'b1, 1'b0, 8'h02, 16'h0000);
    t0 = '0; t1 = '0;
    for (int c = 0; c < 12; c++) begin
      tick();
      t0[c] = Ack0;
      t1[c] = Ack1;
      if (c == 10) begin
        drive_port(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        drive_port(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
      end
    end
    chk("rr_ack0_trace", 64'(t0), 64'h082);
    chk("rr_ack1_trace", 64'(t1), 64'h410);
    chk("rr_rdata0", 64'(RData0), 64'h9304);
    chk("rr_rdata1", 64'(RData1), 64'h2621);

    // Port 0 drops its request during ACCESS: one Ack, no re-grant.
    drive_port(1'b0, 1'b1, 1'b0, 8'h02, 16'h0000);
    s0 = '0; s1 = '0; se = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      s0[c] = Ack0;
      s1[c] = Ack1;
      se[c] = ~Mem_En;
      if (c == 0) drive_port(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
    end
    chk("drop_ack0_trace", 64'(s0), 64'h02);
    chk("drop_ack1_trace", 64'(s1), 64'h00);
    chk("drop_memen_trace", 64'(se), 64'h01);
    chk("drop_rdata0", 64'(RData0), 64'h2621);

    // Reset during ACCESS of a write: abandoned before Memory samples it.
    drive_port(1'b1, 1'b1, 1'b1, 8'h0B, 16'hBEEF);
    tick();
    chk("midrst_en_before", 64'(Mem_En), 64'h0);
    #2 Reset = 1'b0;
    #1;
    chk("midrst_en", 64'(Mem_En), 64'h1);
    chk("midrst_we", 64'(Mem_Write_EN), 64'h1);
    chk("midrst_ack", 64'({Ack0, Ack1}), 64'h0);
    chk("midrst_busy", 64'(Busy), 64'h0);
    drive_port(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
    @(negedge Clk);
    #1 Reset = 1'b1;
    chk("midrst_mem_untouched", 64'(mem[8'h0B]), 64'h0);
    tick();
    chk("midrst_no_ack", 64'({Ack0, Ack1, Busy}), 64'h0);
    run_vec('{port: 1'b0, wr: 1'b0, addr: 8'h0A, wdata: 16'h0000, exp_r0: 16'h0666, exp_r1: 16'h0000},
            "after_rst");

    // Randomized requesters against the reference model.
    Reset = 1'b0;
    @(negedge Clk);
    #1 Reset = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge Clk);
      model_step();
      #1;
      act = 64'({Ack0, Ack1, RData0, RData1, Mem_Address, Mem_DIn, Mem_Write_EN, Mem_En, Busy});
      exp = 64'({m_ack0, m_ack1, m_r0, m_r1, m_addr, m_din, m_we_n, m_en_n, m_busy});
      chk($sformatf("rand_cyc%0d", cyc), act, exp);
      requester(1'b0, Req0, m_ack0);
      requester(1'b1, Req1, m_ack1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
